// File: rtl/alu_exec_unit.sv
// Registered ALU execute stage. Single-cycle ops complete on the accepting edge.
// Multiply takes 32 shift-add edges with Busy high, and start is ignored while Busy.
module alu_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  ALUSelect,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  state_t      state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [5:0]  cnt;

  logic [31:0] single_res;
  logic [31:0] acc_next;

  always_comb begin
    single_res = 32'd0;
    case (ALUSelect)
      OP_AND:  single_res = OpA & OpB;
      OP_OR:   single_res = OpA | OpB;
      OP_ADD:  single_res = OpA + OpB;
      OP_SUB:  single_res = OpA - OpB;
      OP_SLT:  single_res = {31'd0, $signed(OpA) < $signed(OpB)};
      OP_NOR:  single_res = ~(OpA | OpB);
      default: single_res = 32'd0;
    endcase
  end

  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      acc    <= 32'd0;
      cnt    <= 6'd0;
      Result <= 32'd0;
      Zero   <= 1'b1;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (ALUSelect == OP_MUL) begin
              mcand  <= OpA;
              mplier <= OpB;
              acc    <= 32'd0;
              cnt    <= 6'd0;
              Busy   <= 1'b1;
              state  <= MUL;
            end else begin
              Result <= single_res;
              Zero   <= (single_res == 32'd0);
              Done   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
          // Last iteration: publish the accumulator including this edge's add.
          if (cnt == 6'd31) begin
            Result <= acc_next;
            Zero   <= (acc_next == 32'd0);
            Done   <= 1'b1;
            Busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver queues expected results, and a
// negedge monitor pops one entry per Done pulse.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  ALUSelect = 4'd0;
  logic [31:0] OpA = 32'd0;
  logic [31:0] OpB = 32'd0;
  logic [31:0] Result;
  logic        Zero;
  logic        Busy;
  logic        Done;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .start(start), .ALUSelect(ALUSelect),
    .OpA(OpA), .OpB(OpB), .Result(Result), .Zero(Zero), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    case (code)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b1000: begin
        p = longint'(a) * longint'(b);
        return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  // Monitor: every Done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && Done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("result", Result, e);
        check("zero", {31'd0, Zero}, {31'd0, e == 32'd0});
        check("busy_at_done", {31'd0, Busy}, 32'd0);
      end
    end
  end

  // Drive one request at the current negedge and hold it for one edge.
  task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; ALUSelect = code; OpA = a; OpB = b;
    exp_q.push_back(model(code, a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit poke);
    int n;
    issue(4'b1000, a, b);
    n = 0;
    while (Busy && n < 100) begin
      n++;
      if (poke && n == 5) begin
        start = 1'b1; ALUSelect = 4'b0010; OpA = 32'd7; OpB = 32'd9;
      end else begin
        start = 1'b0;
      end
      if (poke) begin
        OpA = $urandom; OpB = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("mul_busy_cycles", n, 32);
    check("mul_done_after_busy", {31'd0, Done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] codes[8];
    logic [3:0] c;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b1111};

    repeat (3) @(negedge clk);
    check("rst_result", Result, 32'd0);
    check("rst_zero", {31'd0, Zero}, 32'd1);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    rst = 1'b0;

    issue(4'b0010, 32'h5, 32'h3);
    check("add_busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {31'd0, Done}, 32'd0);

    issue(4'b0110, 32'h1234, 32'h1234);
    issue(4'b0110, 32'h0, 32'h1);
    @(negedge clk);

    issue(4'b0111, 32'hFFFFFFFF, 32'h1);
    check("b2b_done_first", {31'd0, Done}, 32'd1);
    issue(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00);
    check("b2b_done_second", {31'd0, Done}, 32'd1);
    @(negedge clk);

    run_mul(32'h00010001, 32'h00000003, 1'b1);
    @(negedge clk);
    run_mul(32'h80000001, 32'h00000004, 1'b0);
    @(negedge clk);

    // Abort a multiply with reset: no Done must follow and the result clears.
    start = 1'b1; ALUSelect = 4'b1000; OpA = 32'hFFFF; OpB = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_result", Result, 32'd0);
    check("abort_zero", {31'd0, Zero}, 32'd1);
    check("abort_done", {31'd0, Done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    issue(4'b1111, 32'hDEADBEEF, 32'h12345678);
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      c = codes[$urandom_range(0, 7)];
      if (c == 4'b1000) begin
        run_mul($urandom, $urandom, 1'b0);
      end else begin
        issue(c, $urandom, $urandom);
      end
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered ALU execution stage that consumes the 4-bit `ALUSelect` code produced by the ALU control decoder, together with two 32-bit operands, and returns a result with a start/done handshake. Logic and add/sub/slt codes complete in one cycle. An added multiply code runs as a 32-iteration shift-add sequence. The block sits in the execute stage between the register-file read ports and the write-back mux, and stalls the datapath through `Busy`.

## Interface
- No parameters; datapath width is fixed at 32 bits and the code width at 4 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request to execute; sampled on the rising edge of `clk`.
- `ALUSelect` input 4: operation code, sampled with `start`.
- `OpA` input 32: operand A, sampled with `start`.
- `OpB` input 32: operand B, sampled with `start`.
- `Result` output 32: registered result; holds its value until the next completion.
- `Zero` output 1: high when `Result == 0`; updated with `Result`.
- `Busy` output 1: high while a multiply is in progress; `start` is ignored while high.
- `Done` output 1: one-cycle pulse marking that `Result` has just been updated.

## Operation
- Codes:
  - 0000: AND.
  - 0001: OR.
  - 0010: add, modulo 2^32, no overflow flag.
  - 0110: subtract A−B, modulo 2^32.
  - 0111: signed set-less-than; the result is 1 or 0, zero-extended.
  - 1100: NOR.
  - 1000: multiply; the result is the low 32 bits of the unsigned product A×B.
- Any other code: `Result`=0, `Zero`=1, and `Done` pulses normally. This is not an error.
- FSM states:
  - IDLE: `Busy`=0.
  - MUL: `Busy`=1.
- IDLE, `start`=1 with a single-cycle code: at that edge, compute and register `Result`/`Zero` and set `Done`=1. Stay in IDLE.
- IDLE, `start`=1 with code 1000: latch multiplicand=`OpA`, multiplier=`OpB`, accumulator=0, counter=0. Go to MUL, `Busy`=1, `Done`=0.
- MUL, each edge:
  - If multiplier bit 0 is 1, accumulator += multiplicand, mod 2^32.
  - Shift the multiplicand left 1 and the multiplier right 1.
  - Increment the counter.
  - On the edge where the counter goes 31→32, `Result` takes the final accumulator, `Done`=1, `Busy`=0, and the state returns to IDLE.
- `Result` and `Zero` do not change during MUL; they hold the previous result.
- `Done` is high for exactly one cycle after each completion and is 0 otherwise.
- `start` in MUL is ignored. Nothing is queued, and upstream must hold the request until `Busy`=0.
- `start` in the cycle where `Done`=1 (state IDLE) is accepted. Back-to-back single-cycle ops therefore give `Done` high on consecutive cycles.
- Reset values, asserted asynchronously on `rst`:
  - State IDLE.
  - `Result`=0, `Zero`=1, `Busy`=0, `Done`=0.
  - Counter and internal registers 0.
- Reset during MUL aborts the multiply. No `Done` is produced, and `Result` is 0 after reset.

## Timing
- Single-cycle op, `start` sampled at edge k:
  - `Result`, `Zero` valid and `Done`=1 after edge k.
  - `Done`=0 after edge k+1 unless another op is issued.
- Multiply, `start` sampled at edge k:
  - `Busy`=1 after edges k through k+31, which is 32 cycles.
  - After edge k+32: `Busy`=0, `Done`=1, `Result` valid.
  - Total latency is 32 edges from acceptance. The earliest next accepted `start` is at edge k+33.
- Operands and code are captured at acceptance. Changes on `OpA`/`OpB`/`ALUSelect` during MUL have no effect.
- `rst` deassertion is synchronous to `clk` from the integrator's side. The first `start` is honoured on the first rising edge with `rst`=0.

## Test plan
- Reset, then add: `start` with code 0010, A=0x00000005, B=0x00000003 → one cycle later `Result`=0x8, `Zero`=0, `Done`=1 for 1 cycle, `Busy`=0.
- Sub wrap and zero: code 0110 with A=B=0x1234 → `Result`=0, `Zero`=1. Then code 0110 with A=0, B=1 → `Result`=0xFFFFFFFF.
- Signed SLT, then back-to-back ops on consecutive cycles:
  - Code 0111, A=0xFFFFFFFF, B=1 → `Result`=1.
  - Next cycle, code 0000, A=0xF0F0F0F0, B=0xFF00FF00 → `Result`=0xF000F000.
  - `Done` is high on both cycles.
- Multiply with ignored start:
  - Code 1000, A=0x00010001, B=0x00000003 → `Busy` high exactly 32 cycles, then `Result`=0x00030003 with a single `Done` pulse.
  - A `start` with code 0010 issued mid-run is ignored, and no extra `Done` appears.
- Multiply overflow truncation: code 1000, A=0x80000001, B=0x00000004 → `Result`=0x00000004.
- Reset mid-multiply and unknown code:
  - Assert `rst` 10 cycles into a multiply → `Busy`=0, `Result`=0, `Zero`=1, and no `Done`.
  - Afterwards, code 1111 → `Result`=0, `Done`=1 pulse.
